// File: rtl/hex_scroll_ctrl_if.sv
// Digit write port for hex_scroll_ctrl: valid/ready handshake carrying one hex digit.
interface hex_scroll_ctrl_if;
  logic       wr_valid;
  logic [3:0] wr_data;
  logic       wr_ready;

  modport master (output wr_valid, output wr_data, input wr_ready);
  modport slave  (input wr_valid, input wr_data, output wr_ready);
endinterface

// File: rtl/hex_scroll_ctrl.sv
// Six-digit seven-segment message controller: buffers hex digits, shows them static or scrolling.
// Optional HEX_BLINK_EN: blink the displays while scrolling is paused.
module hex_scroll_ctrl #(
  parameter int STEP_CYCLES = 12500000,
  parameter int DEPTH       = 16,
  parameter int CW          = 5
) (
  input  logic              CLOCK_50,
  input  logic              resetn,
  hex_scroll_ctrl_if.slave  wr,
  input  logic              clear,
  input  logic              run,
  output logic [CW-1:0]     count,
  output logic              scrolling,
  output logic [6:0]        HEX0,
  output logic [6:0]        HEX1,
  output logic [6:0]        HEX2,
  output logic [6:0]        HEX3,
  output logic [6:0]        HEX4,
  output logic [6:0]        HEX5
);
  localparam int PW = $clog2(STEP_CYCLES);

  typedef enum logic [1:0] {ST_EMPTY, ST_HOLD, ST_SCROLL} state_t;

  state_t        r_state;
  logic [CW-1:0] r_count;
  logic [CW-1:0] r_head;
  logic [PW-1:0] r_pre;
  logic          r_scrolling;
  logic [3:0]    r_buf [DEPTH];
  logic [6:0]    r_hex [6];
`ifdef HEX_BLINK_EN
  logic          r_paused;
  logic          r_phase;
`endif

  logic          w_accept;
  logic          w_tc;
  logic          w_blank;
  logic [CW:0]   w_sum  [6];
  logic [CW-2:0] w_idx  [6];
  logic          w_show [6];
  logic [6:0]    w_win  [6];

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'h0: seg7 = 7'h40;  4'h1: seg7 = 7'h79;  4'h2: seg7 = 7'h24;  4'h3: seg7 = 7'h30;
      4'h4: seg7 = 7'h19;  4'h5: seg7 = 7'h12;  4'h6: seg7 = 7'h02;  4'h7: seg7 = 7'h78;
      4'h8: seg7 = 7'h00;  4'h9: seg7 = 7'h10;  4'hA: seg7 = 7'h08;  4'hB: seg7 = 7'h03;
      4'hC: seg7 = 7'h46;  4'hD: seg7 = 7'h21;  4'hE: seg7 = 7'h06;  default: seg7 = 7'h0E;
    endcase
  endfunction

  assign wr.wr_ready = (r_state != ST_SCROLL) && (r_count < CW'(DEPTH)) && resetn;
  assign w_accept    = wr.wr_valid && wr.wr_ready;
  assign w_tc        = (r_pre == PW'(STEP_CYCLES - 1));

`ifdef HEX_BLINK_EN
  assign w_blank = r_paused && r_phase;
`else
  assign w_blank = 1'b0;
`endif

  // head < count always holds, so one conditional subtract implements the modulo
  always_comb begin
    for (int i = 0; i < 6; i++) begin
      w_sum[i]  = {1'b0, r_head} + (CW+1)'(i);
      w_idx[i]  = (w_sum[i] >= {1'b0, r_count}) ? (CW-1)'(w_sum[i] - {1'b0, r_count})
                                                 : (CW-1)'(w_sum[i]);
      w_show[i] = (r_state != ST_EMPTY) && ((r_count > CW'(6)) || (CW'(i) < r_count)) && !w_blank;
      w_win[i]  = w_show[i] ? seg7(r_buf[w_idx[i]]) : 7'h7F;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (resetn && !clear && w_accept) r_buf[r_count[CW-2:0]] <= wr.wr_data;
  end

  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      r_state     <= ST_EMPTY;
      r_count     <= '0;
      r_head      <= '0;
      r_pre       <= '0;
      r_scrolling <= 1'b0;
`ifdef HEX_BLINK_EN
      r_paused    <= 1'b0;
      r_phase     <= 1'b0;
`endif
    end else if (clear) begin
      r_state     <= ST_EMPTY;
      r_count     <= '0;
      r_head      <= '0;
      r_pre       <= '0;
      r_scrolling <= 1'b0;
`ifdef HEX_BLINK_EN
      r_paused    <= 1'b0;
      r_phase     <= 1'b0;
`endif
    end else begin
      case (r_state)
        ST_EMPTY: if (w_accept) r_state <= ST_HOLD;
        ST_HOLD: begin
          if (run && (r_count > CW'(6))) begin
            r_state     <= ST_SCROLL;
            r_scrolling <= 1'b1;
            r_pre       <= '0;
`ifdef HEX_BLINK_EN
            r_paused    <= 1'b0;
          end else if (r_paused) begin
            r_pre <= w_tc ? '0 : r_pre + 1'b1;
            if (w_tc) r_phase <= ~r_phase;
`endif
          end
        end
        ST_SCROLL: begin
          r_pre <= w_tc ? '0 : r_pre + 1'b1;
          if (w_tc) r_head <= (r_head == r_count - 1'b1) ? '0 : r_head + 1'b1;
          // a step landing on the pause edge still completes; the pause restarts the period
          if (!run) begin
            r_state     <= ST_HOLD;
            r_scrolling <= 1'b0;
            r_pre       <= '0;
`ifdef HEX_BLINK_EN
            r_paused    <= 1'b1;
            r_phase     <= 1'b0;
`endif
          end
        end
        default: r_state <= ST_EMPTY;
      endcase
      if (w_accept) begin
        r_count  <= r_count + 1'b1;
`ifdef HEX_BLINK_EN
        r_paused <= 1'b0;
`endif
      end
    end
  end

  always_ff @(posedge CLOCK_50) begin
    for (int i = 0; i < 6; i++) begin
      if (!resetn) r_hex[i] <= 7'h7F;
      else         r_hex[i] <= w_win[i];
    end
  end

  assign count     = r_count;
  assign scrolling = r_scrolling;
  assign HEX5      = r_hex[0];
  assign HEX4      = r_hex[1];
  assign HEX3      = r_hex[2];
  assign HEX2      = r_hex[3];
  assign HEX1      = r_hex[4];
  assign HEX0      = r_hex[5];
endmodule
